fpu_result_stage: RTL
=====================

# fpu_result_stage

Post-processing stage placed directly downstream of the five-stage FPU core. It captures operand classification and sign information at issue time and carries it through a tag delay line aligned to the core latency. When the core's unsigned exponent/fraction result emerges, it merges that result with the tag to produce a signed IEEE-754 single result with special-value handling (NaN/Inf/zero) and status flags. Results are buffered in a small FIFO with a valid/ready output handshake.

## Interface
- DataSize, 32: operand/result width
- ExponentSize, 8: exponent width
- FractionSize, 23: fraction width
- CoreLatency, 6: cycles from the FPU core's operand sample to a stable core Result
- FifoDepth, 4: result FIFO entries (power of 2)

- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- InValid  in  1  operation issued this cycle (same cycle Operand1/2/Operation are presented to the core)
- Operand1, Operand2  in  32  operands, mirrored from core inputs
- Operation  in  2  [1]=0 ADD/SUB, 1 MUL/DIV; [0]=0 ADD/MUL, 1 SUB/DIV
- CoreResult  in  31  core {FinalExponent, FinalFraction}; the core sign bit is ignored
- OutReady  in  1  consumer accepts the head entry
- OutValid  out  1  FIFO non-empty
- Result  out  32  head entry; 0 when empty
- Flags  out  3  {Invalid, Overflow, Zero} of the head entry; 0 when empty
- Count  out  3  occupancy, 0..FifoDepth
- DropErr  out  1  sticky; a result was lost because the FIFO was full

## Operation
- Classify each operand at issue:
  - NaN: exp=FF, frac≠0
  - Inf: exp=FF, frac=0
  - Zero: exp=0; denormals are flushed to zero
  - Normal: otherwise
- Effective sign of Operand2: s2e = s2 XOR Operation[0] for ADD/SUB.
- ADD/SUB sign: the sign of the operand with the larger {exp,frac} magnitude, using s2e for Operand2.
  - Equal magnitudes with s1≠s2e give +0.
- MUL sign: s1 XOR s2.
- The tag {valid, class1, class2, sign, op, zeroHint} shifts through CoreLatency registers. At the last stage it combines with CoreResult, in this priority order:
  - Operation=2'b11 (DIV, unsupported) → 0x7FC00000, Invalid.
  - Either operand NaN → 0x7FC00000, Invalid.
  - ADD/SUB with Inf and Inf of opposite effective sign → NaN, Invalid. MUL of Inf by Zero → NaN, Invalid.
  - Otherwise, either operand Inf → {sign, FF, 0}.
  - ADD/SUB with both Zero → −0 only if s1=1 and s2e=1, else +0, Zero flag.
  - ADD/SUB with one Zero → the other operand with its effective sign.
  - MUL with any Zero → {sign, 0}, Zero flag.
  - Equal-magnitude cancellation → +0, Zero flag.
  - Normal: {sign, CoreResult}. If the exponent is FF → {sign, FF, 0}, Overflow. If the exponent is 0 → {sign, 0}, Zero flag.
- FIFO behaviour:
  - Push when the last tag stage is valid. Pop when OutValid & OutReady.
  - Full with push and no pop: drop the new entry and set DropErr.
  - Full with push and pop in the same cycle: both happen; Count is unchanged.
  - Empty with pop: not possible, since OutValid=0.
- Reset values: all tag valid bits, Count, OutValid, Result, Flags and DropErr are 0. In-flight core results are discarded, because the core itself has no reset.

## Timing
- Cycle 0: InValid=1; the tag is captured at the end of cycle 0.
- Cycles 1..6: the tag occupies stages 0..5. CoreResult for this operation is stable in cycle 6, coincident with stage 5.
- The FIFO is written at the end of cycle 6. If the FIFO was empty, OutValid=1 in cycle 7, so latency is 7 cycles.
- Back-to-back issue on every cycle yields one push per cycle.
- Result and Flags are registered FIFO outputs and change only on a pop or on a write into an empty FIFO.
- An RST_N assertion at any point clears state immediately. Operations issued before reset never produce OutValid.

## Test plan
- 0x3FC00000 + 0x40200000 (op 00), OutReady=1 → cycle 7: OutValid=1, Result=0x40800000, Flags=000. Then 0xC0400000 + 0x3F800000 → Result=0xC0000000.
- MUL 0xC0000000 × 0x40400000 (op 10) → Result=0xC0C00000, Flags=000.
- Specials:
  - 0x7F800000 − 0x7F800000 (op 01) → 0x7FC00000, Invalid=1.
  - 0x7F800000 × 0x00000000 → 0x7FC00000, Invalid=1.
  - op 11 → 0x7FC00000, Invalid=1.
- Zeros:
  - 0x3F800000 − 0x3F800000 → 0x00000000, Zero=1.
  - 0x80000000 + 0x80000000 → 0x80000000, Zero=1.
  - 0x80000000 × 0x40000000 → 0x80000000.
- Backpressure: OutReady=0, six consecutive issues → Count=4, DropErr=1, the first four retained. OutReady=1 → four pops in issue order over four cycles, then OutValid=0, DropErr stays 1.
- Reset: issue in cycle 0, RST_N=0 in cycle 3, released in cycle 4 → OutValid stays 0 through cycle 12; all outputs 0; a new issue afterwards completes with normal latency.

Source files
------------

// File: rtl/fpu_result_stage.sv
// fpu_result_stage: tags FPU core results with operand class/sign, resolves IEEE special cases, buffers in a FIFO
module fpu_result_stage #(
    parameter int DataSize     = 32,
    parameter int ExponentSize = 8,
    parameter int FractionSize = 23,
    parameter int CoreLatency  = 6,
    parameter int FifoDepth    = 4
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               InValid,
    input  logic [DataSize-1:0]                Operand1,
    input  logic [DataSize-1:0]                Operand2,
    input  logic [1:0]                         Operation,
    input  logic [DataSize-2:0]                CoreResult,
    input  logic                               OutReady,
    output logic                               OutValid,
    output logic [DataSize-1:0]                Result,
    output logic [2:0]                         Flags,
    output logic [$clog2(FifoDepth+1)-1:0]     Count,
    output logic                               DropErr
);
    localparam int AW = $clog2(FifoDepth);
    localparam int CW = $clog2(FifoDepth + 1);
    localparam logic [DataSize-1:0] QNAN = {1'b0, {ExponentSize{1'b1}}, 1'b1, {(FractionSize-1){1'b0}}};

    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    typedef struct packed {
        logic       valid;
        cls_t       c1;
        cls_t       c2;
        logic       sign;
        logic [1:0] op;
        logic       zero_hint;
    } tag_t;

    function automatic cls_t classify(input logic [DataSize-1:0] v);
        logic [ExponentSize-1:0] e;
        logic [FractionSize-1:0] f;
        e = v[DataSize-2 -: ExponentSize];
        f = v[FractionSize-1:0];
        return (&e) ? ((|f) ? CLS_NAN : CLS_INF) : (~|e) ? CLS_ZERO : CLS_NORM;
    endfunction

    tag_t                      issue_tag;
    tag_t [CoreLatency-1:0]    tags;
    tag_t                      last;
    logic                      s1, s2e, both_zero, any_zero, cancel;
    logic [DataSize-2:0]       mag1, mag2;
    logic [ExponentSize-1:0]   exp_r;
    logic                      inf1, inf2, inf_any, bad, ovf, zflag;
    logic [DataSize-1:0]       inf_val, zero_val, push_data;
    logic [2:0]                push_flags;
    logic [DataSize+2:0]       mem [FifoDepth];
    logic [DataSize+2:0]       head_next;
    logic [AW-1:0]             wr_ptr, rd_ptr, rd_nx;
    logic                      push, pop, full, wr_en;

    // Issue-time classification; zero_hint marks an exactly-zero result (ADD/SUB cancellation or
    // both zero, MUL with a zero). For Inf-Inf it also flags opposite effective signs.
    always_comb begin
        s1 = Operand1[DataSize-1];
        s2e = Operand2[DataSize-1] ^ (~Operation[1] & Operation[0]);
        mag1 = Operand1[DataSize-2:0];
        mag2 = Operand2[DataSize-2:0];
        issue_tag.valid = InValid;
        issue_tag.c1 = classify(Operand1);
        issue_tag.c2 = classify(Operand2);
        issue_tag.op = Operation;
        both_zero = (issue_tag.c1 == CLS_ZERO) && (issue_tag.c2 == CLS_ZERO);
        any_zero = (issue_tag.c1 == CLS_ZERO) || (issue_tag.c2 == CLS_ZERO);
        cancel = (mag1 == mag2) && (s1 != s2e);
        issue_tag.sign = Operation[1] ? (s1 ^ s2e) : both_zero ? (s1 & s2e) : cancel ? 1'b0 : (mag1 >= mag2) ? s1 : s2e;
        issue_tag.zero_hint = Operation[1] ? any_zero : (both_zero | cancel);
    end

    // Tag delay line aligned with the core latency
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tags <= '0;
        else tags <= {tags[CoreLatency-2:0], issue_tag};
    end

    // Merge the emerging core result with its tag, resolving special values by priority
    always_comb begin
        last = tags[CoreLatency-1];
        exp_r = CoreResult[DataSize-2 -: ExponentSize];
        inf1 = last.c1 == CLS_INF;
        inf2 = last.c2 == CLS_INF;
        inf_any = inf1 | inf2;
        bad = (last.op == 2'b11) || (last.c1 == CLS_NAN) || (last.c2 == CLS_NAN) ||
              (last.op[1] ? ((inf1 && last.c2 == CLS_ZERO) || (inf2 && last.c1 == CLS_ZERO)) : (inf1 & inf2 & last.zero_hint));
        inf_val = {last.sign, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
        zero_val = {last.sign, {(DataSize-1){1'b0}}};
        ovf = !bad && !inf_any && !last.zero_hint && (&exp_r);
        zflag = !bad && !inf_any && (last.zero_hint || (~|exp_r));
        push_data = bad ? QNAN : inf_any ? inf_val : last.zero_hint ? zero_val :
                    (&exp_r) ? inf_val : (~|exp_r) ? zero_val : {last.sign, CoreResult};
        push_flags = {bad, ovf, zflag};
    end

    // FIFO control and next head value (head is held in the output registers)
    always_comb begin
        push = last.valid;
        pop = OutValid & OutReady;
        full = Count == CW'(FifoDepth);
        wr_en = push & (~full | pop);
        rd_nx = rd_ptr + 1'b1;
        head_next = pop ? ((Count > CW'(1)) ? mem[rd_nx] : wr_en ? {push_data, push_flags} : '0) : {push_data, push_flags};
    end

    // FIFO storage
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= {push_data, push_flags};
    end

    // FIFO pointers, occupancy, registered head and sticky drop error
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count <= '0;
            Result <= '0;
            Flags <= '0;
            DropErr <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_nx;
            Count <= Count + CW'(wr_en) - CW'(pop);
            if (push && !wr_en) DropErr <= 1'b1;
            if (pop || (wr_en && Count == '0)) {Result, Flags} <= head_next;
        end
    end

    assign OutValid = Count != '0;
endmodule
